// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the single-port SRAM controller.
//   state_t   : controller FSM states (zero-fill, then normal service)
//   RSP_DEPTH : number of read responses the controller can hold
package sram_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam int RSP_DEPTH = 2;

endpackage

// File: rtl/sram_sp_ctrl_if.sv
// Request/response bus between a requester (cache, predictor) and the SRAM controller.
//   w_valid/w_ready/w_addr/w_data : write request channel
//   r_valid/r_ready/r_addr        : read request channel
//   rsp_valid/rsp_ready/rsp_data  : read response channel, responses in request order
// The master modport is the requester side; the slave modport is the controller side.
interface sram_sp_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 7
);
    logic              w_valid;
    logic              w_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] r_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output w_valid, w_addr, w_data, r_valid, r_addr, rsp_ready,
        input  w_ready, r_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  w_valid, w_addr, w_data, r_valid, r_addr, rsp_ready,
        output w_ready, r_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram_rsp_buf.sv
// Two-entry response FIFO holding captured SRAM read data.
//   CLK, RST        : clock, synchronous active-high reset (clears pointers/count only)
//   push, push_data : write one entry
//   pop, pop_data   : pop_data is the oldest entry; pop removes it
//   count, full, empty : occupancy status
module sram_rsp_buf
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [1:0]        count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [RSP_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == 2'(RSP_DEPTH));
    assign empty    = (count == 2'd0);
endmodule

// File: rtl/sram_sp_ctrl.sv
// Initiator for a single-port SRAM macro. Serialises write and read requests onto the
// one macro port, captures registered read data into a 2-entry response buffer, and
// zero-fills the whole array after reset (INIT_EN=1) before accepting requests.
//   CLK, RST          : clock (shared with the macro), synchronous active-high reset
//   bus (slave)       : write/read request channels and read response channel
//   init_done         : high once the zero-fill is complete
//   SRAM_CEB/WEB      : macro chip/write enable, active-low
//   SRAM_A/SRAM_D     : macro address / write data
//   SRAM_Q            : macro read data, valid only in the cycle after a read
module sram_sp_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = 7,
    parameter int INIT_EN = 1
) (
    input  logic              CLK,
    input  logic              RST,
    sram_sp_ctrl_if.slave     bus,
    output logic              init_done,
    output logic              SRAM_CEB,
    output logic              SRAM_WEB,
    output logic [ADDR_W-1:0] SRAM_A,
    output logic [DATA_W-1:0] SRAM_D,
    input  logic [DATA_W-1:0] SRAM_Q
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] init_addr;
    logic              prio_rd;
    logic              rd_vld_p1;
    logic              rd_oob_p1;

    logic [1:0]        buf_count;
    logic              buf_full;
    logic              buf_empty;
    logic              pop;
    logic [2:0]        occ;
    logic              credit_ok;
    logic              idle;
    logic              rd_req;
    logic              wr_grant;
    logic              rd_grant;
    logic              w_oob;
    logic              r_oob;

    // Requests are only serviced in IDLE and never while reset is held.
    assign idle = (state == ST_IDLE) && !RST;

    assign pop = !buf_empty && bus.rsp_ready;

    // Occupancy the buffer will have once this cycle's pop and the in-flight read land.
    // Counting the pop keeps one read per cycle possible with rsp_ready held high.
    assign occ       = {1'b0, buf_count} + {2'b00, rd_vld_p1} - {2'b00, pop};
    assign credit_ok = (occ < 3'(RSP_DEPTH)) && !(buf_full && !pop);

    assign w_oob = ({1'b0, bus.w_addr} >= DEPTH_L);
    assign r_oob = ({1'b0, bus.r_addr} >= DEPTH_L);

    assign rd_req   = bus.r_valid && credit_ok;
    assign wr_grant = idle && bus.w_valid && !(prio_rd && rd_req);
    assign rd_grant = idle && rd_req && !wr_grant;

    assign bus.w_ready = idle && !rd_grant;
    assign bus.r_ready = idle && credit_ok && !wr_grant;

    // Macro port drive; out-of-range accesses keep the macro deselected.
    always_comb begin
        SRAM_CEB = 1'b1;
        SRAM_WEB = 1'b1;
        SRAM_A   = '0;
        SRAM_D   = '0;
        if (!RST) begin
            if (state == ST_INIT) begin
                SRAM_CEB = 1'b0;
                SRAM_WEB = 1'b0;
                SRAM_A   = init_addr;
            end else if (wr_grant) begin
                SRAM_CEB = w_oob;
                SRAM_WEB = 1'b0;
                SRAM_A   = bus.w_addr;
                SRAM_D   = bus.w_data;
            end else if (rd_grant) begin
                SRAM_CEB = r_oob;
                SRAM_A   = bus.r_addr;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= (INIT_EN != 0) ? ST_INIT : ST_IDLE;
            init_addr <= '0;
            init_done <= (INIT_EN == 0);
            prio_rd   <= 1'b0;
            rd_vld_p1 <= 1'b0;
            rd_oob_p1 <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == ADDR_W'(DEPTH - 1)) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    // A write that beats a waiting read hands the next slot to the read.
                    if (rd_grant)
                        prio_rd <= 1'b0;
                    else if (wr_grant && rd_req)
                        prio_rd <= 1'b1;
                end
            endcase
            // ---- stage p1: read issued last cycle, macro Q valid now ----
            rd_vld_p1 <= rd_grant;
            rd_oob_p1 <= rd_grant && r_oob;
        end
    end

    sram_rsp_buf #(.DATA_W(DATA_W)) u_rsp_buf (
        .CLK       (CLK),
        .RST       (RST),
        .push      (rd_vld_p1),
        .push_data (rd_oob_p1 ? '0 : SRAM_Q),
        .pop       (pop),
        .pop_data  (bus.rsp_data),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign bus.rsp_valid = !buf_empty;
endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Self-checking bench for sram_sp_ctrl: a behavioural SRAM macro per DUT, a reference
// array plus expected-response queue for the full-size instance, and a second
// instance with DEPTH < 2**ADDR_W for out-of-range accesses.
module tb_sram_sp_ctrl;

    logic        CLK = 1'b0;
    logic        RST;

    logic        init_done,  ceb,  web;
    logic [6:0]  a;
    logic [63:0] d, q;
    logic        init_done2, ceb2, web2;
    logic [6:0]  a2;
    logic [63:0] d2, q2;

    logic [63:0] mem1 [128];
    logic [63:0] mem2 [128];
    logic [63:0] ref_mem [128];
    logic [63:0] exp_q [$];

    int n_vec  = 0;
    int n_err  = 0;
    int acc_r  = 0;
    int max_q  = 0;
    int base;

    sram_sp_ctrl_if #(.DATA_W(64), .ADDR_W(7)) b ();
    sram_sp_ctrl_if #(.DATA_W(64), .ADDR_W(7)) b2 ();

    sram_sp_ctrl #(.DATA_W(64), .DEPTH(128), .ADDR_W(7), .INIT_EN(1)) dut (
        .CLK(CLK), .RST(RST), .bus(b), .init_done(init_done),
        .SRAM_CEB(ceb), .SRAM_WEB(web), .SRAM_A(a), .SRAM_D(d), .SRAM_Q(q)
    );

    sram_sp_ctrl #(.DATA_W(64), .DEPTH(96), .ADDR_W(7), .INIT_EN(0)) dut2 (
        .CLK(CLK), .RST(RST), .bus(b2), .init_done(init_done2),
        .SRAM_CEB(ceb2), .SRAM_WEB(web2), .SRAM_A(a2), .SRAM_D(d2), .SRAM_Q(q2)
    );

    always #5 CLK = ~CLK;

    // Macro models: registered read data, garbage whenever no read happened.
    always @(posedge CLK) begin
        if (!ceb && !web) mem1[a] <= d;
        if (!ceb && web) q <= mem1[a];
        else             q <= {$urandom, $urandom};
        if (!ceb2 && !web2) mem2[a2] <= d2;
        if (!ceb2 && web2) q2 <= mem2[a2];
        else               q2 <= {$urandom, $urandom};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One cycle: account handshakes mid-cycle, then move to the next falling edge.
    task automatic step();
        #1;
        if (b.rsp_valid && b.rsp_ready) begin
            if (exp_q.size() == 0) check("rsp unexpected", 64'd1, 64'd0);
            else                   check("rsp data", b.rsp_data, exp_q.pop_front());
        end
        if (b.w_valid && b.w_ready) ref_mem[b.w_addr] = b.w_data;
        if (b.r_valid && b.r_ready) begin
            exp_q.push_back(ref_mem[b.r_addr]);
            acc_r++;
        end
        if (exp_q.size() > max_q) max_q = exp_q.size();
        @(negedge CLK);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        b.w_valid = 1'b0; b.r_valid = 1'b0; b.rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic init_seq();
        for (int i = 0; i < 128; i++) begin
            #1;
            check("init ctl", {58'd0, ceb, web, b.rsp_valid, b.w_ready, b.r_ready, init_done}, 64'd0);
            check("init A", 64'(a), 64'(i));
            check("init D", d, 64'd0);
            @(negedge CLK);
        end
        #1;
        check("init done", 64'(init_done), 64'd1);
        check("init readys", {62'd0, b.w_ready, b.r_ready}, 64'd3);
        check("idle ceb", 64'(ceb), 64'd1);
    endtask

    initial begin
        RST = 1'b1;
        b.w_valid = 0; b.w_addr = 0; b.w_data = 0; b.r_valid = 0; b.r_addr = 0; b.rsp_ready = 0;
        b2.w_valid = 0; b2.w_addr = 0; b2.w_data = 0; b2.r_valid = 0; b2.r_addr = 0; b2.rsp_ready = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 64'd0;

        // Reset values
        repeat (3) @(negedge CLK);
        #1;
        check("rst readys", {61'd0, b.w_ready, b.r_ready, b.rsp_valid}, 64'd0);
        check("rst init_done", 64'(init_done), 64'd0);
        check("rst macro", {55'd0, ceb, web, a}, {55'd0, 2'b11, 7'd0});
        check("rst D", d, 64'd0);
        check("rst init_done2", 64'(init_done2), 64'd1);
        RST = 1'b0;

        // 1: zero-fill, then read of 5 returns 0
        init_seq();
        b.r_valid = 1'b1; b.r_addr = 7'd5; b.rsp_ready = 1'b1;
        step();
        drain(10);

        // 2: write then read, response two cycles after the read grant
        b.w_valid = 1'b1; b.w_addr = 7'd3; b.w_data = 64'hDEAD_BEEF;
        #1;
        check("t2 wr port", {55'd0, ceb, web, a}, {55'd0, 2'b00, 7'd3});
        check("t2 wr D", d, 64'hDEAD_BEEF);
        step();
        b.w_valid = 1'b0; b.r_valid = 1'b1; b.r_addr = 7'd3;
        #1;
        check("t2 rd grant", {61'd0, b.r_ready, ceb, web}, 64'b101);
        step();
        b.r_valid = 1'b0;
        #1;
        check("t2 rv N+1", 64'(b.rsp_valid), 64'd0);
        step();
        #1;
        check("t2 rv N+2", 64'(b.rsp_valid), 64'd1);
        check("t2 rdata", b.rsp_data, 64'hDEAD_BEEF);
        step();
        drain(10);

        // 3: both sides requesting addr 9 -> W,R,W,R...
        for (int k = 0; k < 8; k++) begin
            b.w_valid = 1'b1; b.w_addr = 7'd9; b.w_data = 64'hA000 + 64'(k);
            b.r_valid = 1'b1; b.r_addr = 7'd9; b.rsp_ready = 1'b1;
            #1;
            check("t3 grant", {62'd0, b.w_ready, b.r_ready}, (k % 2 == 0) ? 64'b10 : 64'b01);
            step();
        end
        drain(10);

        // 4: stalled consumer: two reads accepted, writes still go through
        for (int i = 0; i < 4; i++) begin
            b.w_valid = 1'b1; b.w_addr = 7'(20 + i); b.w_data = 64'hC0 + 64'(i);
            step();
        end
        base = acc_r;
        b.w_valid = 1'b0; b.rsp_ready = 1'b0; b.r_valid = 1'b1;
        repeat (6) begin
            b.r_addr = 7'(20 + acc_r - base);
            step();
        end
        #1;
        check("t4 accepted", 64'(acc_r - base), 64'd2);
        check("t4 r_ready", 64'(b.r_ready), 64'd0);
        b.w_valid = 1'b1; b.w_addr = 7'd60; b.w_data = 64'h6060;
        #1;
        check("t4 wr while full", {61'd0, b.w_ready, ceb, web}, 64'b100);
        step();
        b.w_valid = 1'b0; b.rsp_ready = 1'b1;
        for (int n = 0; n < 20 && (acc_r - base) < 4; n++) begin
            b.r_addr = 7'(20 + acc_r - base);
            step();
        end
        check("t4 total", 64'(acc_r - base), 64'd4);
        drain(10);

        // 5: reset right after a read grant
        b.r_valid = 1'b1; b.r_addr = 7'd20; b.rsp_ready = 1'b1;
        #1;
        check("t5 rd grant", 64'(b.r_ready), 64'd1);
        step();
        b.r_valid = 1'b0; RST = 1'b1;
        step();
        RST = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 128; i++) ref_mem[i] = 64'd0;
        init_seq();

        // 6: random traffic against the reference array
        base = acc_r;
        max_q = 0;
        for (int c = 0; c < 12000; c++) begin
            b.w_valid   = 1'($urandom_range(0, 1));
            b.w_addr    = 7'($urandom_range(0, 15));
            b.w_data    = {$urandom, $urandom};
            b.r_valid   = 1'($urandom_range(0, 1));
            b.r_addr    = 7'($urandom_range(0, 15));
            b.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(20);
        check("t6 activity", 64'((acc_r - base) > 2000), 64'd1);
        check("t6 max outstanding", 64'(max_q <= 2), 64'd1);

        // 7: out-of-range accesses on the DEPTH=96 instance
        b2.rsp_ready = 1'b1;
        b2.w_valid = 1'b1; b2.w_addr = 7'd100; b2.w_data = 64'h55;
        #1;
        check("oob wr", {62'd0, b2.w_ready, ceb2}, 64'b11);
        @(negedge CLK);
        b2.w_addr = 7'd10; b2.w_data = 64'h1234;
        #1;
        check("t7 wr ceb", 64'(ceb2), 64'd0);
        @(negedge CLK);
        b2.w_valid = 1'b0; b2.r_valid = 1'b1; b2.r_addr = 7'd100;
        #1;
        check("oob rd", {62'd0, b2.r_ready, ceb2}, 64'b11);
        @(negedge CLK);
        b2.r_addr = 7'd10;
        #1;
        check("t7 rd", {61'd0, b2.r_ready, ceb2, web2}, 64'b101);
        @(negedge CLK);
        b2.r_valid = 1'b0;
        #1;
        check("oob rsp valid", 64'(b2.rsp_valid), 64'd1);
        check("oob rsp data", b2.rsp_data, 64'd0);
        @(negedge CLK);
        #1;
        check("t7 rsp valid", 64'(b2.rsp_valid), 64'd1);
        check("t7 rsp data", b2.rsp_data, 64'h1234);
        @(negedge CLK);
        #1;
        check("t7 rsp empty", 64'(b2.rsp_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
